// File: rtl/nvm_spike_scheduler.sv
// Wishbone master that expands queued input-spike events into synapse reads for the NVM neuron core.
// Optional ack timeout: define NVM_SCHED_TIMEOUT_EN to abandon unacknowledged accesses after ACK_TIMEOUT cycles.
//
// state | meaning
// IDLE  | waiting for a queued event; pops and starts the column sweep
// SYN   | synapse-matrix read for (row, col) in flight
// GAP   | one bus-idle cycle between accesses; picks the next access
// DONE  | picture-done write in flight
// SPK   | spike-out read in flight
// OUT   | frame result offered on spike_valid_o until consumed

module nvm_spike_scheduler #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          NUM_COLS    = 32,
  parameter logic [31:0] SYN_ADDR    = 32'h3000_0000,
  parameter logic [31:0] DONE_ADDR   = 32'h3000_1000,
  parameter logic [31:0] SPIKE_ADDR  = 32'h3000_2000,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        evt_valid_i,
  output logic        evt_ready_o,
  input  logic [4:0]  evt_row_i,
  input  logic        evt_last_i,
  input  logic [15:0] stim_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  output logic        spike_valid_o,
  output logic [3:0]  spike_o,
  input  logic        spike_ready_i,
  output logic        busy_o,
  output logic        err_timeout_o
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [4:0] LAST_COL = 5'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYN,
    S_GAP,
    S_DONE,
    S_SPK,
    S_OUT
  } state_t;

  state_t state;

  // event queue of {last, row}
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [4:0]    head_row;
  logic          head_last;

  assign fifo_full   = (fifo_cnt == CNT_FULL);
  assign fifo_empty  = (fifo_cnt == '0);
  assign evt_ready_o = !fifo_full;
  assign push        = evt_valid_i && !fifo_full;
  assign pop         = (state == S_IDLE) && !fifo_empty;
  assign head_row    = mem[rd_ptr][4:0];
  assign head_last   = mem[rd_ptr][5];

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= {evt_last_i, evt_row_i};
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  logic in_access;
  logic tmo_hit;

  assign in_access = (state == S_SYN) || (state == S_DONE) || (state == S_SPK);

`ifdef NVM_SCHED_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  // counter sits at zero outside an access, so every access entry starts from zero
  assign tmo_hit = in_access && !m_ack_i && (tmo_cnt == 8'(ACK_TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (in_access && !tmo_hit) ? tmo_cnt + 8'd1 : 8'd0;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout_o = err_q;
`else
  assign tmo_hit       = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{m_dat_i[31:4], ACK_TIMEOUT[7:0]};

  logic [4:0]  row_q;
  logic [4:0]  col_q;
  logic        last_q;
  logic        after_done;
  logic        acc_end;

  assign acc_end = m_ack_i || tmo_hit;
  assign m_sel_o = 4'hF;
  assign busy_o  = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      last_q        <= 1'b0;
      after_done    <= 1'b0;
      m_cyc_o       <= 1'b0;
      m_stb_o       <= 1'b0;
      m_we_o        <= 1'b0;
      m_adr_o       <= '0;
      m_dat_o       <= '0;
      spike_valid_o <= 1'b0;
      spike_o       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            row_q      <= head_row;
            last_q     <= head_last;
            col_q      <= '0;
            after_done <= 1'b0;
            m_cyc_o    <= 1'b1;
            m_stb_o    <= 1'b1;
            m_we_o     <= 1'b0;
            m_adr_o    <= SYN_ADDR;
            m_dat_o    <= {2'b00, head_row, 5'd0, 4'b0000, stim_i};
            state      <= S_SYN;
          end
        end
        S_SYN, S_DONE: begin
          if (acc_end) begin
            after_done <= (state == S_DONE);
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_adr_o    <= '0;
            m_dat_o    <= '0;
            state      <= S_GAP;
          end
        end
        S_GAP: begin
          if (after_done) begin
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b0;
            m_adr_o <= SPIKE_ADDR;
            m_dat_o <= '0;
            state   <= S_SPK;
          end else if (col_q < LAST_COL) begin
            col_q   <= col_q + 5'd1;
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b0;
            m_adr_o <= SYN_ADDR;
            m_dat_o <= {2'b00, row_q, col_q + 5'd1, 4'b0000, stim_i};
            state   <= S_SYN;
          end else if (last_q) begin
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= 1'b1;
            m_adr_o <= DONE_ADDR;
            m_dat_o <= '0;
            state   <= S_DONE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SPK: begin
          if (acc_end) begin
            // an abandoned spike read reports no spikes
            spike_o       <= tmo_hit ? 4'h0 : m_dat_i[3:0];
            spike_valid_o <= 1'b1;
            m_cyc_o       <= 1'b0;
            m_stb_o       <= 1'b0;
            m_adr_o       <= '0;
            state         <= S_OUT;
          end
        end
        S_OUT: begin
          if (spike_ready_i) begin
            spike_valid_o <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_spike_scheduler.sv
// Directed bench for nvm_spike_scheduler: sweep, frame end, queue full, reset, push/pop overlap.
// With NVM_SCHED_TIMEOUT_EN a second instance (ACK_TIMEOUT=4, never acked) covers the timeout path.

module tb_nvm_spike_scheduler;

  localparam int          NCOLS  = 2;
  localparam logic [31:0] SYN_A  = 32'h3000_0000;
  localparam logic [31:0] DONE_A = 32'h3000_1000;
  localparam logic [31:0] SPK_A  = 32'h3000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        evt_valid, evt_ready, evt_last;
  logic [4:0]  evt_row;
  logic [15:0] stim;
  logic        m_cyc, m_stb, m_we, m_ack;
  logic [3:0]  m_sel;
  logic [31:0] m_adr, m_dat, m_dat_in;
  logic        spike_valid, spike_ready, busy, err;
  logic [3:0]  spike;
  logic        ack_en;
  logic [31:0] spike_dat;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int idle_viol = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    int          cyc;
  } acc_t;
  acc_t log_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  assign m_ack    = ack_en && m_cyc && m_stb;
  assign m_dat_in = (m_cyc && m_adr == SPK_A) ? spike_dat : 32'h0;

  always @(negedge clk) begin
    if (m_cyc && m_stb && m_ack) log_q.push_back('{m_we, m_adr, m_dat, cyc_n});
    if (!m_cyc && (m_we || m_adr != 32'h0 || m_dat != 32'h0)) idle_viol <= idle_viol + 1;
  end

  nvm_spike_scheduler #(.FIFO_DEPTH(8), .NUM_COLS(NCOLS), .ACK_TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .evt_valid_i(evt_valid), .evt_ready_o(evt_ready), .evt_row_i(evt_row),
    .evt_last_i(evt_last), .stim_i(stim),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_dat_i(m_dat_in), .m_ack_i(m_ack),
    .spike_valid_o(spike_valid), .spike_o(spike), .spike_ready_i(spike_ready),
    .busy_o(busy), .err_timeout_o(err)
  );

`ifdef NVM_SCHED_TIMEOUT_EN
  logic        t_valid, t_ready, t_cyc, t_stb, t_we, t_sv, t_busy, t_err, t_sready;
  logic [3:0]  t_sel, t_spike;
  logic [31:0] t_adr, t_dat;
  int          t_run = 0;
  int          t_runs[$];

  always @(negedge clk) begin
    if (t_stb) t_run <= t_run + 1;
    else if (t_run != 0) begin
      t_runs.push_back(t_run);
      t_run <= 0;
    end
  end

  nvm_spike_scheduler #(.FIFO_DEPTH(8), .NUM_COLS(NCOLS), .ACK_TIMEOUT(4)) dut_tmo (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .evt_valid_i(t_valid), .evt_ready_o(t_ready), .evt_row_i(5'd2),
    .evt_last_i(1'b1), .stim_i(stim),
    .m_cyc_o(t_cyc), .m_stb_o(t_stb), .m_we_o(t_we), .m_sel_o(t_sel),
    .m_adr_o(t_adr), .m_dat_o(t_dat), .m_dat_i(32'h5), .m_ack_i(1'b0),
    .spike_valid_o(t_sv), .spike_o(t_spike), .spike_ready_i(t_sready),
    .busy_o(t_busy), .err_timeout_o(t_err)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] row, input logic last);
    evt_valid = 1'b1;
    evt_row   = row;
    evt_last  = last;
    tick();
    evt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL %s: busy_o still 1 after %0d cycles, required 0", name, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #3;
    total++; if (m_cyc !== 1'b0 || m_stb !== 1'b0 || m_we !== 1'b0) begin bad++; $display("FAIL reset_ctl: cyc/stb/we=%b%b%b required 000", m_cyc, m_stb, m_we); end
    total++; if (m_adr !== 32'h0 || m_dat !== 32'h0) begin bad++; $display("FAIL reset_bus: adr=%h dat=%h required 0", m_adr, m_dat); end
    total++; if (m_sel !== 4'hF) begin bad++; $display("FAIL reset_sel: got %h required f", m_sel); end
    total++; if (spike_valid !== 1'b0 || spike !== 4'h0) begin bad++; $display("FAIL reset_spike: valid=%b spike=%h required 0/0", spike_valid, spike); end
    total++; if (busy !== 1'b0 || err !== 1'b0 || evt_ready !== 1'b1) begin bad++; $display("FAIL reset_status: busy=%b err=%b ready=%b required 0 0 1", busy, err, evt_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sweep;
    int e;
    ack_en = 1'b1;
    stim   = 16'h0040;
    log_q.delete();
    push(5'd3, 1'b0);
    e = cyc_n;
    wait_idle(30, "sweep_idle");
    total++; if (log_q.size() != 2) begin bad++; $display("FAIL sweep_count: %0d accesses, required 2", log_q.size()); end
    if (log_q.size() == 2) begin
      total++; if (log_q[0].adr !== SYN_A || log_q[0].we !== 1'b0 || log_q[0].dat !== 32'h0600_0040) begin bad++; $display("FAIL sweep_acc0: adr=%h we=%b dat=%h required %h 0 06000040", log_q[0].adr, log_q[0].we, log_q[0].dat, SYN_A); end
      total++; if (log_q[1].adr !== SYN_A || log_q[1].we !== 1'b0 || log_q[1].dat !== 32'h0610_0040) begin bad++; $display("FAIL sweep_acc1: adr=%h we=%b dat=%h required %h 0 06100040", log_q[1].adr, log_q[1].we, log_q[1].dat, SYN_A); end
      total++; if (log_q[0].cyc != e + 1) begin bad++; $display("FAIL sweep_latency: first stb in cycle %0d, required %0d", log_q[0].cyc, e + 1); end
      total++; if (log_q[1].cyc - log_q[0].cyc != 2) begin bad++; $display("FAIL sweep_spacing: stb pulses %0d apart, required 2", log_q[1].cyc - log_q[0].cyc); end
    end
  endtask

  task automatic test_frame;
    int n = 0;
    logic held = 1'b1;
    ack_en    = 1'b1;
    spike_dat = 32'h5;
    log_q.delete();
    push(5'd1, 1'b1);
    while (!spike_valid && n < 40) begin tick(); n++; end
    total++; if (spike_valid !== 1'b1) begin bad++; $display("FAIL frame_valid: spike_valid_o=%b after %0d cycles, required 1", spike_valid, n); end
    total++; if (spike !== 4'h5) begin bad++; $display("FAIL frame_spike: spike_o=%h required 5", spike); end
    total++; if (log_q.size() != 4) begin bad++; $display("FAIL frame_count: %0d accesses, required 4", log_q.size()); end
    if (log_q.size() == 4) begin
      total++; if (log_q[2].adr !== DONE_A || log_q[2].we !== 1'b1 || log_q[2].dat !== 32'h0) begin bad++; $display("FAIL frame_done: adr=%h we=%b dat=%h required %h 1 0", log_q[2].adr, log_q[2].we, log_q[2].dat, DONE_A); end
      total++; if (log_q[3].adr !== SPK_A || log_q[3].we !== 1'b0) begin bad++; $display("FAIL frame_spk: adr=%h we=%b required %h 0", log_q[3].adr, log_q[3].we, SPK_A); end
      total++; if (log_q[3].cyc - log_q[2].cyc != 2) begin bad++; $display("FAIL frame_gap: done->spk %0d cycles, required 2", log_q[3].cyc - log_q[2].cyc); end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (spike_valid !== 1'b1) held = 1'b0;
    end
    total++; if (held !== 1'b1) begin bad++; $display("FAIL frame_hold: spike_valid_o dropped without ready, required held 1"); end
    spike_ready = 1'b1;
    tick();
    spike_ready = 1'b0;
    total++; if (spike_valid !== 1'b0) begin bad++; $display("FAIL frame_release: spike_valid_o=%b after ready, required 0", spike_valid); end
    total++; if (spike !== 4'h5) begin bad++; $display("FAIL frame_keep: spike_o=%h required 5", spike); end
    wait_idle(10, "frame_idle");
  endtask

  task automatic test_full;
    int acc = 0;
    int n   = 0;
    int k   = 0;
    logic [4:0] r = 5'd1;
    ack_en = 1'b0;
    log_q.delete();
    push(5'd0, 1'b0);
    while (!m_stb && n < 10) begin tick(); n++; end
    evt_valid = 1'b1;
    evt_last  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic took;
      evt_row = r;
      took = evt_ready;
      tick();
      if (took) begin acc++; r = r + 5'd1; end
    end
    total++; if (acc != 8) begin bad++; $display("FAIL full_accepted: %0d events taken, required 8", acc); end
    total++; if (evt_ready !== 1'b0) begin bad++; $display("FAIL full_ready: evt_ready_o=%b required 0", evt_ready); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL full_err: err_timeout_o=%b required 0", err); end
    ack_en = 1'b1;
    n = 0;
    while (acc < 9 && n < 30) begin
      logic took;
      evt_row = r;
      took = evt_ready;
      tick();
      n++;
      if (took) begin acc++; r = r + 5'd1; end
    end
    evt_valid = 1'b0;
    total++; if (acc != 9) begin bad++; $display("FAIL full_ninth: %0d events taken after pop, required 9", acc); end
    wait_idle(200, "full_drain");
    foreach (log_q[i]) begin
      if (log_q[i].dat[24:20] == 5'd0) begin
        total++;
        if (log_q[i].dat[29:25] !== 5'(k)) begin bad++; $display("FAIL full_order: event %0d row %0d, required %0d", k, log_q[i].dat[29:25], k); end
        k++;
      end
    end
    total++; if (k != 10) begin bad++; $display("FAIL full_events: %0d sweeps seen, required 10", k); end
  endtask

  task automatic test_push_pop;
    int k = 0;
    logic [4:0] exp_rows [3];
    exp_rows[0] = 5'd10; exp_rows[1] = 5'd11; exp_rows[2] = 5'd12;
    ack_en = 1'b0;
    log_q.delete();
    push(5'd10, 1'b0);
    push(5'd11, 1'b0);
    tick();
    ack_en = 1'b1;
    repeat (4) tick();
    evt_valid = 1'b1;
    evt_row   = 5'd12;
    evt_last  = 1'b0;
    tick();
    evt_valid = 1'b0;
    total++; if (dut.fifo_cnt !== 4'd1) begin bad++; $display("FAIL pp_occupancy: occupancy %0d, required 1", dut.fifo_cnt); end
    total++; if (evt_ready !== 1'b1) begin bad++; $display("FAIL pp_ready: evt_ready_o=%b required 1", evt_ready); end
    wait_idle(60, "pp_drain");
    foreach (log_q[i]) begin
      if (log_q[i].dat[24:20] == 5'd0 && k < 3) begin
        total++;
        if (log_q[i].dat[29:25] !== exp_rows[k]) begin bad++; $display("FAIL pp_order: event %0d row %0d, required %0d", k, log_q[i].dat[29:25], exp_rows[k]); end
        k++;
      end
    end
    total++; if (k != 3) begin bad++; $display("FAIL pp_events: %0d sweeps seen, required 3", k); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    ack_en = 1'b0;
    push(5'd4, 1'b1);
    push(5'd5, 1'b0);
    push(5'd6, 1'b0);
    while (!m_stb && n < 10) begin tick(); n++; end
    total++; if (m_stb !== 1'b1) begin bad++; $display("FAIL rst_setup: m_stb_o=%b required 1", m_stb); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin bad++; $display("FAIL rst_async: cyc=%b stb=%b required 0 0", m_cyc, m_stb); end
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || evt_ready !== 1'b1) begin bad++; $display("FAIL rst_after: busy=%b ready=%b required 0 1", busy, evt_ready); end
    repeat (3) tick();
    total++; if (m_cyc !== 1'b0 || spike_valid !== 1'b0) begin bad++; $display("FAIL rst_discard: cyc=%b valid=%b required 0 0", m_cyc, spike_valid); end
  endtask

`ifdef NVM_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int n = 0;
    t_runs.delete();
    total++; if (t_err !== 1'b0) begin bad++; $display("FAIL tmo_init: err_timeout_o=%b required 0", t_err); end
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    while (!t_sv && n < 80) begin tick(); n++; end
    tick();
    total++; if (t_sv !== 1'b1) begin bad++; $display("FAIL tmo_valid: spike_valid_o=%b required 1", t_sv); end
    total++; if (t_err !== 1'b1) begin bad++; $display("FAIL tmo_err: err_timeout_o=%b required 1", t_err); end
    total++; if (t_spike !== 4'h0) begin bad++; $display("FAIL tmo_spike: spike_o=%h required 0", t_spike); end
    total++; if (t_runs.size() != 4) begin bad++; $display("FAIL tmo_accesses: %0d accesses, required 4", t_runs.size()); end
    foreach (t_runs[i]) begin
      total++;
      if (t_runs[i] != 4) begin bad++; $display("FAIL tmo_len: access %0d stb high %0d cycles, required 4", i, t_runs[i]); end
    end
    t_sready = 1'b1;
    tick();
    t_sready = 1'b0;
    total++; if (t_sv !== 1'b0 || t_err !== 1'b1) begin bad++; $display("FAIL tmo_after: valid=%b err=%b required 0 1", t_sv, t_err); end
  endtask
`endif

  initial begin
    rst = 1'b1; evt_valid = 1'b0; evt_row = '0; evt_last = 1'b0; stim = 16'h0;
    spike_ready = 1'b0; ack_en = 1'b0; spike_dat = 32'h0;
`ifdef NVM_SCHED_TIMEOUT_EN
    t_valid = 1'b0; t_sready = 1'b0;
`endif
    test_reset();
    test_sweep();
    test_frame();
    test_full();
    test_push_pop();
    test_reset_mid();
`ifdef NVM_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    total++; if (idle_viol != 0) begin bad++; $display("FAIL bus_idle: %0d cycles with adr/dat/we nonzero while cyc low, required 0", idle_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
